disp_page_sched: RTL and testbench

DISP_PAGE_SCHED -- requirements
Module: disp_page_sched

---
 rtl/disp_sched_pkg.sv | 15 +
 rtl/rr_next_sel.sv | 31 +++
 rtl/disp_page_sched.sv | 144 ++++++++++++++
 tb/tb_disp_page_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display page scheduler.
package disp_sched_pkg;

  localparam int CH_MAX = 4;
  localparam int PAGE_W = $clog2(CH_MAX);

  typedef logic [15:0] hex_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/rr_next_sel.sv
// Combinational round-robin search for the next valid channel after (or at) start.
module rr_next_sel
  import disp_sched_pkg::*;
#(
  parameter int NUM_CH = CH_MAX
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [PAGE_W-1:0] start,
  input  logic              incl_start,
  output logic [PAGE_W-1:0] sel,
  output logic              found
);

  logic [PAGE_W-1:0] idx_v;
  logic              hit_v;

  // Offsets 1..NUM_CH reach start last; with incl_start the scan is 0..NUM_CH-1 instead.
  always_comb begin
    sel   = start;
    found = 1'b0;
    idx_v = start;
    hit_v = 1'b0;
    for (int k = 0; k <= NUM_CH; k++) begin
      idx_v = PAGE_W'((int'(start) + k) % NUM_CH);
      hit_v = !found && (incl_start ? (k < NUM_CH) : (k > 0)) && valid[idx_v];
      sel   = hit_v ? idx_v : sel;
      found = found | hit_v;
    end
  end

endmodule

// File: rtl/disp_page_sched.sv
// Rotates display pages across requesting channels with a dwell timer.
// Optional inter-page blank gap enabled by DISP_PAGE_SCHED_BLANK_EN.
module disp_page_sched
  import disp_sched_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DWELL_CNT   = 50_000_000,
  parameter int DWELL_WIDTH = 26,
  parameter int BLANK_CNT   = 5_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      ch_valid,
  input  hex_word_t [NUM_CH-1:0] ch_data,
  input  logic                   next_tick,
  input  logic                   hold,
  output logic [3:0]             hex0,
  output logic [3:0]             hex1,
  output logic [3:0]             hex2,
  output logic [3:0]             hex3,
  output logic                   blank,
  output logic [PAGE_W-1:0]      page,
  output logic                   page_tick
);

  state_t                 state_r;
  logic [PAGE_W-1:0]      page_r;
  logic [DWELL_WIDTH-1:0] dwell_r;
  hex_word_t              hex_r;
  logic                   blank_r;
  logic                   page_tick_r;

  logic [PAGE_W-1:0]      rr_sel_s;
  logic                   rr_found_s;
  logic                   expire_s;
  logic                   advance_s;

`ifdef DISP_PAGE_SCHED_BLANK_EN
  localparam int BLANK_W = (BLANK_CNT > 1) ? $clog2(BLANK_CNT) : 1;
  logic [BLANK_W-1:0]     blank_cnt_r;
`else
  logic                   unused_cfg_s;
  assign unused_cfg_s = ^32'(BLANK_CNT);
`endif

  // From IDLE the current page itself may be picked; on advance the search starts after it.
  rr_next_sel #(.NUM_CH(NUM_CH)) u_rr_next_sel (
    .valid      (ch_valid),
    .start      (page_r),
    .incl_start (state_r == ST_IDLE),
    .sel        (rr_sel_s),
    .found      (rr_found_s)
  );

  assign expire_s  = (state_r == ST_SHOW) && !hold && (dwell_r == DWELL_WIDTH'(DWELL_CNT - 1));
  assign advance_s = (state_r == ST_SHOW) && (expire_s || next_tick || !ch_valid[page_r]);

  // Scheduler FSM with dwell timer and registered display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      page_r      <= '0;
      dwell_r     <= '0;
      hex_r       <= 16'h0000;
      blank_r     <= 1'b1;
      page_tick_r <= 1'b0;
`ifdef DISP_PAGE_SCHED_BLANK_EN
      blank_cnt_r <= '0;
`endif
    end else begin
      page_tick_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rr_found_s) begin
            state_r     <= ST_SHOW;
            page_r      <= rr_sel_s;
            page_tick_r <= (rr_sel_s != page_r);
            dwell_r     <= '0;
            blank_r     <= 1'b0;
            hex_r       <= ch_data[rr_sel_s];
          end else begin
            blank_r <= 1'b1;
            hex_r   <= 16'h0000;
          end
        end
        ST_SHOW: begin
          if (!advance_s) begin
            hex_r   <= ch_data[page_r];
            dwell_r <= hold ? dwell_r : dwell_r + DWELL_WIDTH'(1);
          end else if (!rr_found_s) begin
            state_r <= ST_IDLE;
            dwell_r <= '0;
            blank_r <= 1'b1;
            hex_r   <= 16'h0000;
          end else if (rr_sel_s == page_r) begin
            dwell_r <= '0;
            hex_r   <= ch_data[page_r];
          end else begin
            page_r      <= rr_sel_s;
            page_tick_r <= 1'b1;
            dwell_r     <= '0;
`ifdef DISP_PAGE_SCHED_BLANK_EN
            state_r     <= ST_BLANK;
            blank_r     <= 1'b1;
            blank_cnt_r <= '0;
`else
            hex_r       <= ch_data[rr_sel_s];
`endif
          end
        end
`ifdef DISP_PAGE_SCHED_BLANK_EN
        ST_BLANK: begin
          if (blank_cnt_r != BLANK_W'(BLANK_CNT - 1)) begin
            blank_cnt_r <= blank_cnt_r + BLANK_W'(1);
          end else if (|ch_valid) begin
            state_r <= ST_SHOW;
            dwell_r <= '0;
            blank_r <= 1'b0;
            hex_r   <= ch_data[page_r];
          end else begin
            state_r <= ST_IDLE;
            hex_r   <= 16'h0000;
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
          dwell_r <= '0;
          blank_r <= 1'b1;
          hex_r   <= 16'h0000;
        end
      endcase
    end
  end

  assign hex0      = hex_r[3:0];
  assign hex1      = hex_r[7:4];
  assign hex2      = hex_r[11:8];
  assign hex3      = hex_r[15:12];
  assign blank     = blank_r;
  assign page      = page_r;
  assign page_tick = page_tick_r;

endmodule

// File: tb/tb_disp_page_sched.sv
// Directed self-checking bench for disp_page_sched (DWELL_CNT=8, BLANK_CNT=3).
module tb_disp_page_sched;
  import disp_sched_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      ch_valid;
  hex_word_t [3:0] ch_data;
  logic            next_tick;
  logic            hold;
  logic [3:0]      hex0, hex1, hex2, hex3;
  logic            blank;
  logic [1:0]      page;
  logic            page_tick;
  logic [19:0]     obs;
  logic [19:0]     exp;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  disp_page_sched #(.NUM_CH(4), .DWELL_CNT(8), .DWELL_WIDTH(4), .BLANK_CNT(3)) dut (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
    .next_tick(next_tick), .hold(hold),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .blank(blank), .page(page), .page_tick(page_tick)
  );

  // {page, page_tick, blank, hex3..hex0}
  assign obs = {page, page_tick, blank, hex3, hex2, hex1, hex0};

  function automatic hex_word_t word_of(int p);
    hex_word_t w;
    w = 16'h1111;
    return 16'(w * 16'(p + 1));
  endfunction

  function automatic logic [19:0] pack(int p, logic tk, logic bl, hex_word_t w);
    return {2'(p), tk, bl, w};
  endfunction

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    ch_valid  = 4'b0000;
    next_tick = 1'b0;
    hold      = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    exp = pack(0, 1'b0, 1'b1, 16'h0000);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_state: got %h expected %h", obs, exp); end
    repeat (3) tick1();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL idle_no_valid: got %h expected %h", obs, exp); end
  endtask

  task automatic test_rotation();
    int p;
    do_reset();
    ch_valid = 4'b1111;
    for (int n = 1; n <= 33; n++) begin
      tick1();
      p   = ((n - 1) / 8) % 4;
      exp = pack(p, (n > 1) && ((n - 1) % 8 == 0), 1'b0, word_of(p));
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL rotation n=%0d: got %h expected %h", n, obs, exp); end
    end
  endtask

  task automatic test_alternate();
    int p;
    do_reset();
    ch_valid = 4'b0101;
    for (int n = 1; n <= 25; n++) begin
      tick1();
      p   = (((n - 1) / 8) % 2) * 2;
      exp = pack(p, (n > 1) && ((n - 1) % 8 == 0), 1'b0, word_of(p));
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL alternate n=%0d: got %h expected %h", n, obs, exp); end
    end
  endtask

  task automatic test_single();
    do_reset();
    ch_valid = 4'b0010;
    for (int n = 1; n <= 20; n++) begin
      tick1();
      exp = pack(1, n == 1, 1'b0, word_of(1));
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL single n=%0d: got %h expected %h", n, obs, exp); end
    end
  endtask

  task automatic test_hold_tick();
    do_reset();
    ch_valid = 4'b1111;
    hold     = 1'b1;
    for (int n = 1; n <= 21; n++) begin
      tick1();
      exp = pack(0, 1'b0, 1'b0, word_of(0));
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL hold n=%0d: got %h expected %h", n, obs, exp); end
    end
    next_tick = 1'b1;
    tick1();
    exp = pack(1, 1'b1, 1'b0, word_of(1));
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL tick_under_hold: got %h expected %h", obs, exp); end
    next_tick = 1'b0;
    hold      = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      tick1();
      exp = pack(1, 1'b0, 1'b0, word_of(1));
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL dwell_page1 n=%0d: got %h expected %h", n, obs, exp); end
    end
    next_tick = 1'b1;
    tick1();
    next_tick = 1'b0;
    exp = pack(2, 1'b1, 1'b0, word_of(2));
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL tick_with_expiry: got %h expected %h", obs, exp); end
    tick1();
    exp = pack(2, 1'b0, 1'b0, word_of(2));
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL single_advance: got %h expected %h", obs, exp); end
  endtask

  task automatic test_valid_drop();
    do_reset();
    ch_valid = 4'b1111;
    repeat (4) tick1();
    ch_valid = 4'b1110;
    tick1();
    exp = pack(1, 1'b1, 1'b0, word_of(1));
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL valid_drop: got %h expected %h", obs, exp); end
    ch_valid = 4'b0000;
    tick1();
    exp = pack(1, 1'b0, 1'b1, 16'h0000);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL all_drop_idle: got %h expected %h", obs, exp); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ch_valid = 4'b1111;
    tick1();
    next_tick = 1'b1;
    tick1();
    next_tick = 1'b0;
    checks++;
    if (page !== 2'd1 || page_tick !== 1'b1) begin
      errors++; $display("FAIL pre_reset_page: got page=%0d tick=%b expected page=1 tick=1", page, page_tick);
    end
    reset = 1'b0;
    #1;
    exp = pack(0, 1'b0, 1'b1, 16'h0000);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL async_reset: got %h expected %h", obs, exp); end
    tick1();
    ch_valid = 4'b0000;
    reset    = 1'b1;
    tick1();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL post_reset_idle: got %h expected %h", obs, exp); end
  endtask

`ifdef DISP_PAGE_SCHED_BLANK_EN
  task automatic test_blank_gap();
    do_reset();
    ch_valid = 4'b1111;
    for (int n = 1; n <= 13; n++) begin
      tick1();
      exp = pack((n >= 9) ? 1 : 0, n == 9, (n >= 9) && (n <= 11), (n <= 11) ? word_of(0) : word_of(1));
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL blank_gap n=%0d: got %h expected %h", n, obs, exp); end
    end
  endtask
`endif

  initial begin
    reset     = 1'b0;
    ch_valid  = 4'b0000;
    next_tick = 1'b0;
    hold      = 1'b0;
    for (int k = 0; k < 4; k++) ch_data[k] = word_of(k);
    test_reset();
    test_single();
`ifdef DISP_PAGE_SCHED_BLANK_EN
    test_blank_gap();
`else
    test_rotation();
    test_alternate();
    test_hold_tick();
    test_valid_drop();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
